prog_host: RTL and testbench



---
 rtl/prog_host_pkg.sv | 7 +
 rtl/prog_host_instr_ram.sv | 21 ++
 rtl/prog_host.sv | 85 ++++++++
 tb/tb_prog_host.sv | 112 +++++++++++
 4 files changed

// File: rtl/prog_host_pkg.sv
// prog_host_pkg: shared widths and FSM state type for the program loader.
package prog_host_pkg;
    localparam int DATA_W = 9;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;
    typedef enum logic [2:0] {IDLE, LOAD, ARMED, RUN, FINISH} prog_state_t;
endpackage

// File: rtl/prog_host_instr_ram.sv
// instr_ram: simple dual-port instruction RAM, registered read returning old data on collision.
module instr_ram #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge Clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
    always_ff @(posedge Clock) begin
        rd_data <= Reset ? '0 : mem[rd_addr];
    end
endmodule

// File: rtl/prog_host.sv
// prog_host: loads a program into instruction RAM, then runs it by counting processor Done pulses.
module prog_host #(
    parameter int DATA_W = prog_host_pkg::DATA_W,
    parameter int ADDR_W = prog_host_pkg::ADDR_W,
    parameter int DEPTH  = prog_host_pkg::DEPTH
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LoadValid,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              LoadLast,
    output logic              LoadReady,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Data,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W:0]   ProgLen,
    output logic [ADDR_W:0]   InstrCount,
    output logic              ProgDone,
    output logic              Overflow
);
    import prog_host_pkg::*;
    localparam logic [ADDR_W:0] ONE = 1;
    prog_state_t state;
    logic [ADDR_W-1:0] wptr;
    logic accept, full, last_done;
    always_comb begin
        LoadReady = state == IDLE || state == LOAD;
        accept    = LoadValid && LoadReady;
        full      = wptr == ADDR_W'(DEPTH - 1);
        last_done = InstrCount + ONE == ProgLen;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            wptr       <= '0;
            ProgLen    <= '0;
            InstrCount <= '0;
            Overflow   <= 1'b0;
            Run        <= 1'b0;
            ProgDone   <= 1'b0;
        end else begin
            ProgDone <= 1'b0;
            case (state)
                IDLE, LOAD: if (accept) begin
                    wptr     <= wptr + ADDR_W'(1);
                    // a full RAM without LoadLast is truncated and treated as the last word
                    Overflow <= full && !LoadLast;
                    if (LoadLast || full) begin
                        ProgLen <= {1'b0, wptr} + ONE;
                        state   <= ARMED;
                    end else state <= LOAD;
                end
                ARMED: if (Start) begin
                    InstrCount <= '0;
                    Run        <= 1'b1;
                    state      <= RUN;
                end
                RUN: if (Done) begin
                    InstrCount <= InstrCount + ONE;
                    if (last_done) begin
                        Run      <= 1'b0;
                        ProgDone <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    wptr  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    instr_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .Clock  (Clock),
        .Reset  (Reset),
        .wr_en  (accept),
        .wr_addr(wptr),
        .wr_data(LoadData),
        .rd_addr(Addr),
        .rd_data(Data)
    );
endmodule

// File: tb/tb_prog_host.sv
// tb_prog_host: directed vector bench for the program loader and run controller.
module tb_prog_host;
    import prog_host_pkg::*;
    logic Clock = 1'b0;
    logic Reset = 1'b1, LoadValid = 1'b0, LoadLast = 1'b0, Start = 1'b0, Done = 1'b0;
    logic [DATA_W-1:0] LoadData = '0;
    logic [ADDR_W-1:0] Addr = '0;
    logic LoadReady, Run, ProgDone, Overflow;
    logic [DATA_W-1:0] Data;
    logic [ADDR_W:0] ProgLen, InstrCount;
    int vectors = 0;
    int errors = 0;

    typedef struct packed {
        logic rs, lv;
        logic [8:0] ld;
        logic ll, st;
        logic [4:0] ad;
        logic dn, chk;
        logic [8:0] d;
        logic rdy, run;
        logic [5:0] plen, cnt;
        logic pd, ovf;
    } vec_t;
    vec_t tbl[$];

    always #5 Clock = ~Clock;

    prog_host dut (
        .Clock(Clock), .Reset(Reset), .LoadValid(LoadValid), .LoadData(LoadData),
        .LoadLast(LoadLast), .LoadReady(LoadReady), .Start(Start), .Addr(Addr),
        .Data(Data), .Run(Run), .Done(Done), .ProgLen(ProgLen), .InstrCount(InstrCount),
        .ProgDone(ProgDone), .Overflow(Overflow)
    );

    function automatic vec_t mk(input logic rs, lv, input logic [8:0] ld, input logic ll, st,
                                input logic [4:0] ad, input logic dn, chk, input logic [8:0] d,
                                input logic rdy, run, input logic [5:0] plen, cnt, input logic pd, ovf);
        return '{rs, lv, ld, ll, st, ad, dn, chk, d, rdy, run, plen, cnt, pd, ovf};
    endfunction

    task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL vector %0d %s: got 0x%h, expected 0x%h", vectors, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        Reset = v.rs; LoadValid = v.lv; LoadData = v.ld; LoadLast = v.ll;
        Start = v.st; Addr = v.ad; Done = v.dn;
        @(posedge Clock);
        #1;
        vectors++;
        if (v.chk) cmp("Data", Data, v.d);
        cmp("LoadReady", 9'(LoadReady), 9'(v.rdy));
        cmp("Run", 9'(Run), 9'(v.run));
        cmp("ProgLen", 9'(ProgLen), 9'(v.plen));
        cmp("InstrCount", 9'(InstrCount), 9'(v.cnt));
        cmp("ProgDone", 9'(ProgDone), 9'(v.pd));
        cmp("Overflow", 9'(Overflow), 9'(v.ovf));
    endtask

    initial begin
        logic [8:0] w [5] = '{9'h040, 9'h048, 9'h0C1, 9'h003, 9'h011};
        // reset state
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        // 32 words without LoadLast: truncation at full depth
        for (int i = 0; i < 32; i++)
            apply(mk(0, 1, 9'(i), 0, 0, 0, 0, 0, 0, i < 31, 0, i == 31 ? 6'd32 : 6'd0, 0, 0, i == 31));
        apply(mk(0, 1, 9'h1FF, 0, 0, 0, 0, 1, 9'h000, 0, 0, 32, 0, 0, 1));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 9'h000, 0, 0, 32, 0, 0, 1));
        // run all 32 with back-to-back Done pulses
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32, 0, 0, 1));
        for (int k = 1; k <= 32; k++)
            apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, k < 32, 32, 6'(k), k == 32, 1));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32, 32, 0, 1));
        // three-word program, ignored inputs, spaced Done pulses
        tbl.push_back(mk(0, 1, 9'h040, 0, 0, 0, 0, 1, 9'h000, 1, 0, 32, 32, 0, 0));
        tbl.push_back(mk(0, 1, 9'h048, 0, 0, 0, 0, 1, 9'h040, 1, 0, 32, 32, 0, 0));
        tbl.push_back(mk(0, 1, 9'h0C1, 1, 0, 1, 0, 1, 9'h048, 0, 0, 3, 32, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1, 9'h0C1, 0, 0, 3, 32, 0, 0));
        tbl.push_back(mk(0, 1, 9'h1FF, 0, 0, 3, 1, 1, 9'h003, 0, 0, 3, 32, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 9'h003, 0, 0, 3, 32, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 9'h048, 0, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9'h1FF, 0, 1, 3, 0, 1, 9'h003, 0, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1, 9'h003, 0, 1, 3, 1, 0, 0));
        for (int g = 0; g < 3; g++) tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 9'h003, 0, 1, 3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1, 9'h003, 0, 1, 3, 2, 0, 0));
        for (int g = 0; g < 3; g++) tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 9'h003, 0, 1, 3, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1, 9'h003, 0, 0, 3, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1, 9'h003, 1, 0, 3, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 1, 9'h0C1, 1, 0, 3, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 9'h040, 1, 0, 3, 3, 0, 0));
        foreach (tbl[i]) apply(tbl[i]);
        // reset in the middle of a run
        for (int j = 0; j < 5; j++)
            apply(mk(0, 1, w[j], j == 4, 0, 0, 0, 0, 0, j < 4, 0, j == 4 ? 6'd5 : 6'd3, 3, 0, 0));
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 1, 0, 0));
        apply(mk(1, 0, 0, 0, 0, 2, 0, 1, 9'h000, 1, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 2, 0, 1, 9'h0C1, 1, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 2, 0, 1, 9'h0C1, 1, 0, 0, 0, 0, 0));
        // same-address read and write returns the old word first
        for (int j = 0; j < 4; j++)
            apply(mk(0, 1, 9'h100 + 9'(j), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        apply(mk(0, 1, 9'h0AA, 0, 0, 4, 0, 1, 9'h011, 1, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 4, 0, 1, 9'h0AA, 1, 0, 0, 0, 0, 0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
